// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared constants, state encodings and the rotated
// priority search used by the four-way round-robin arbiter.
//   ARB_IDLE / ARB_GRANT : FSM state encodings
//   NUM_REQ / IDX_W      : requester count and index width
//   rr_pick()            : first requester at or after a start index
//   idx_onehot()         : index to one-hot grant vector
package rr_arbiter4_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Rotated priority encoder: scans start, start+1, ... (mod NUM_REQ).
  // Walks from the far end so the nearest hit is the one that sticks.
  function automatic pick_t rr_pick(input req_vec_t req, input idx_t start);
    pick_t p;
    idx_t  cand;
    p.found = 1'b0;
    p.idx   = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  function automatic req_vec_t idx_onehot(input idx_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_mux.sv
// Mux4to1: plain 4:1 multiplexer used as the shared datapath select.
//   A..D : data inputs (INPUT_WIDTH bits each)
//   S    : 2-bit select, 0 picks A ... 3 picks D
//   F    : selected data (combinational)
module Mux4to1 #(
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic [INPUT_WIDTH-1:0] A,
  input  logic [INPUT_WIDTH-1:0] B,
  input  logic [INPUT_WIDTH-1:0] C,
  input  logic [INPUT_WIDTH-1:0] D,
  input  logic [1:0]             S,
  output logic [INPUT_WIDTH-1:0] F
);

  always_comb begin
    case (S)
      2'd0:    F = A;
      2'd1:    F = B;
      2'd2:    F = C;
      default: F = D;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter sharing one DATA_W datapath among four
// requesters. Owner is held until it drops req; the next owner is picked at
// the same edge with no idle gap.
// Optional feature macro: RR_ARBITER4_TIMEOUT_EN -- forces rotation after
// MAX_HOLD consecutive grant cycles when another requester is waiting.
//   clk     : clock, all state on posedge
//   rst     : synchronous active-high reset
//   req     : per-requester request/hold
//   din_a..din_d : requester 0..3 data
//   grant   : registered one-hot owner (0 when idle)
//   sel     : registered encoded owner, drives the mux select
//   valid   : registered |grant
//   dout    : data of the requester at sel
//   timeout : one-cycle pulse on forced rotation (0 without the feature)
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] din_c,
  input  logic [DATA_W-1:0] din_d,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              timeout
);

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be >= 2");
  end

  logic [0:0] state, state_n;
  idx_t       ptr, ptr_n;
  idx_t       sel_n;
  req_vec_t   grant_n;
  logic       valid_n;
  logic       timeout_n;

  pick_t      pick_idle;
  pick_t      pick_next;

  // Candidates: from ptr when idle; after the owner when it releases.
  always_comb begin
    pick_idle = rr_pick(req, ptr);
    pick_next = rr_pick(req, sel + IDX_W'(1));
  end

`ifdef RR_ARBITER4_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  pick_t             pick_other;

  // On expiry the owner still requests, so it must be masked out of the search.
  always_comb begin
    pick_other = rr_pick(req & ~idx_onehot(sel), sel + IDX_W'(1));
  end
`endif

  // Next-state / next-output logic.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    grant_n   = grant;
    timeout_n = 1'b0;
`ifdef RR_ARBITER4_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
`endif

    case (state)
      ARB_IDLE: begin
        if (pick_idle.found) begin
          state_n = ARB_GRANT;
          sel_n   = pick_idle.idx;
          grant_n = idx_onehot(pick_idle.idx);
`ifdef RR_ARBITER4_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end
      end

      ARB_GRANT: begin
        if (!req[sel]) begin
          // Release: the owner's slot is empty, so searching all four from
          // sel+1 visits exactly the other three in order.
          ptr_n = sel + IDX_W'(1);
          if (pick_next.found) begin
            sel_n   = pick_next.idx;
            grant_n = idx_onehot(pick_next.idx);
          end else begin
            state_n = ARB_IDLE;
            grant_n = '0;
          end
`ifdef RR_ARBITER4_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end
`ifdef RR_ARBITER4_TIMEOUT_EN
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          hold_cnt_n = '0;
          if (pick_other.found) begin
            ptr_n     = sel + IDX_W'(1);
            sel_n     = pick_other.idx;
            grant_n   = idx_onehot(pick_other.idx);
            timeout_n = 1'b1;
          end
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
`endif
      end

      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase

    valid_n = |grant_n;
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      sel     <= '0;
      grant   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
`ifdef RR_ARBITER4_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      grant   <= grant_n;
      valid   <= valid_n;
      timeout <= timeout_n;
`ifdef RR_ARBITER4_TIMEOUT_EN
      hold_cnt <= hold_cnt_n;
`endif
    end
  end

  Mux4to1 #(.INPUT_WIDTH(DATA_W)) u_mux (
    .A (din_a),
    .B (din_b),
    .C (din_c),
    .D (din_d),
    .S (sel),
    .F (dout)
  );

endmodule
